ping_responder: RTL
===================

Name: ping_responder

Overview:
- Emulates a single-wire ultrasonic ranging sensor: the responder end of the trigger/echo protocol that the sensor-interface logic initiates.
- Detects a host trigger pulse on the shared signal line, waits a fixed holdoff, then drives an echo pulse whose width encodes a programmed distance in cm.
- Used for hardware-in-loop testing of the navigation logic on the Nexys 3 without physical sensors, one instance per sensor line.
- The top level wraps SIG_OUT/SIG_OE into the inout pad.

Parameters:
- TRIG_MIN_CYC, 200: minimum accepted trigger high width in clocks (2 us at 100 MHz).
- TRIG_MAX_CYC, 2000: maximum accepted trigger high width in clocks (20 us).
- HOLDOFF_CYC, 75000: clocks from trigger acceptance to echo rise (750 us).
- CYC_PER_CM, 5800: echo clocks per cm (58 us/cm round trip).
- ECHO_MIN_CYC, 11500: lower clamp on echo width (115 us).
- ECHO_MAX_CYC, 1850000: upper clamp on echo width (18.5 ms).
- RECOVER_CYC, 20000: dead time after echo before a new trigger is accepted (200 us).

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST_N  in  1  asynchronous reset, active low.
- SIG_IN  in  1  pad input, asynchronous to CLK.
- SIG_OUT  out  1  value driven onto the pad when SIG_OE=1.
- SIG_OE  out  1  pad drive enable.
- DISTANCE  in  8  simulated target distance in cm.
- BUSY  out  1  high in any state other than IDLE.
- ECHO_DONE  out  1  one-cycle pulse on the cycle the echo falls.

Behaviour:
- Reset (asynchronous, RST_N=0): SIG_OUT=0, SIG_OE=0, BUSY=0, ECHO_DONE=0, state=IDLE, all counters=0, sync flops=0. Assertion during any state, including mid-echo, releases the pad immediately.
- Synchronizer: SIG_IN passes through a 2-flop synchronizer to produce s_sig, and edges are detected on s_sig against its previous value. While SIG_OE=1, s_sig is ignored.
- States: IDLE, TRIG, HOLDOFF, ECHO, RELEASE, RECOVER.
- IDLE:
  - A rising edge of s_sig moves to TRIG and clears the counter.
  - A line that is already high at reset exit is not a trigger; a low must be seen first.
- TRIG:
  - Count clocks while s_sig=1, saturating at TRIG_MAX_CYC+1.
  - On the falling edge: if TRIG_MIN_CYC <= count <= TRIG_MAX_CYC, latch DISTANCE into d_lat, compute the width and go to HOLDOFF. Otherwise return to IDLE with no response.
- Width rule:
  - w = d_lat*CYC_PER_CM, unsigned, computed at 22 bits with no overflow.
  - w_clamped = max(ECHO_MIN_CYC, min(w, ECHO_MAX_CYC)).
  - DISTANCE=0 gives ECHO_MIN_CYC. DISTANCE=255 gives 1479000.
  - DISTANCE changes after latching have no effect on the current cycle.
- HOLDOFF:
  - Wait exactly HOLDOFF_CYC clocks counted from the cycle after the falling edge is detected.
  - On the next cycle, SIG_OE=1 and SIG_OUT=1 together, and the state moves to ECHO.
- ECHO:
  - SIG_OUT stays high for exactly w_clamped clocks.
  - On the following edge, SIG_OUT=0, ECHO_DONE pulses, and the state moves to RELEASE.
- RELEASE: one clock with SIG_OE=1 and SIG_OUT=0 (actively drive low), then SIG_OE=0 and go to RECOVER.
- RECOVER:
  - RECOVER_CYC clocks during which all s_sig activity is ignored, then go to IDLE.
  - A trigger arriving during RECOVER is dropped entirely, even if it is still high when IDLE is entered.
- Host latency, measured from the synchronized trigger fall to echo rise: HOLDOFF_CYC+1 clocks, plus 2 clocks of synchronizer delay from the pad.
- Counter: a single 22-bit down or up counter shared across states; no wrap is possible within the parameter ranges above.

Optional Feature:
- PING_NO_TARGET_EN.
- Defined: DISTANCE=8'hFF means "no object", and the echo width is forced to ECHO_MAX_CYC (1850000), ignoring the multiply.
- Undefined: 8'hFF is an ordinary distance (1479000 clocks).
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then DISTANCE=10 and a 500-clock trigger: echo rises 75001 clocks after the synchronized fall, is high for 58000 clocks, ECHO_DONE fires once, and SIG_OE drops 1 clock after the echo falls.
- 150-clock trigger (too short) and a 2500-clock trigger (too long): no SIG_OE assertion, and BUSY returns to 0 after the falling edge.
- DISTANCE=0 gives an echo of 11500 clocks. DISTANCE=255 gives 1479000 clocks without the macro and 1850000 with PING_NO_TARGET_EN.
- DISTANCE changed from 10 to 200 during HOLDOFF: echo is still 58000 clocks. The next trigger yields 1160000.
- Second trigger issued 10000 clocks after the echo falls (inside RECOVER): no response. A trigger at 25000 clocks after the fall: normal response.
- RST_N pulled low halfway through the echo: SIG_OE and SIG_OUT go to 0 with no clock edge. After release, a valid trigger produces a correct echo.

Source files
------------

// File: rtl/ping_responder.sv
// ping_responder: responder end of a single-wire ultrasonic ranging sensor.
// Detects a host trigger pulse, waits a fixed holdoff, then drives an echo
// pulse whose width is DISTANCE (cm) times CYC_PER_CM, clamped.
// Optional build macro PING_NO_TARGET_EN: DISTANCE=8'hFF forces the maximum
// echo width ("no object") instead of the multiply.
module ping_responder #(
  parameter int unsigned TRIG_MIN_CYC = 200,
  parameter int unsigned TRIG_MAX_CYC = 2000,
  parameter int unsigned HOLDOFF_CYC  = 75000,
  parameter int unsigned CYC_PER_CM   = 5800,
  parameter int unsigned ECHO_MIN_CYC = 11500,
  parameter int unsigned ECHO_MAX_CYC = 1850000,
  parameter int unsigned RECOVER_CYC  = 20000
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sig_in_i,
  input  logic [7:0] distance_i,
  output logic       sig_out_o,
  output logic       sig_oe_o,
  output logic       busy_o,
  output logic       echo_done_o
);

  localparam int unsigned CNT_W = 22;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_HOLDOFF,
    S_ECHO,
    S_RELEASE,
    S_RECOVER
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [7:0]         d_lat_q, d_lat_d;
  logic               armed_q, armed_d;
  logic               sig_out_d, sig_oe_d, busy_d, echo_done_d;
  logic               sync1_q, sync2_q, prev_q;
  logic [1:0]         vld_q;
  logic               s_sig_c, rise_c, fall_c;
  logic [CNT_W-1:0]   w_raw_c, w_clamp_c;

  assign s_sig_c = sync2_q;
  assign rise_c  = s_sig_c & ~prev_q;
  assign fall_c  = ~s_sig_c & prev_q;

  // Two-flop synchronizer, edge history, and a marker for when s_sig holds a real pad sample.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= sig_in_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
    end
  end

  // Echo width from the latched distance, clamped to the legal window.
  always_comb begin
    w_raw_c   = CNT_W'(d_lat_q) * CNT_W'(CYC_PER_CM);
    w_clamp_c = w_raw_c;
    if (w_raw_c > CNT_W'(ECHO_MAX_CYC)) w_clamp_c = CNT_W'(ECHO_MAX_CYC);
    if (w_raw_c < CNT_W'(ECHO_MIN_CYC)) w_clamp_c = CNT_W'(ECHO_MIN_CYC);
`ifdef PING_NO_TARGET_EN
    if (d_lat_q == 8'hFF) w_clamp_c = CNT_W'(ECHO_MAX_CYC);
`else
`endif
  end

  // Next-state, shared counter and registered pad/status outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    d_lat_d     = d_lat_q;
    armed_d     = 1'b0;
    sig_out_d   = 1'b0;
    sig_oe_d    = 1'b0;
    echo_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Only a low seen in IDLE arms edge detection: a line already high
        // at reset exit or left high from RECOVER is not a trigger.
        armed_d = armed_q | (vld_q[1] & ~s_sig_c);
        if (armed_q && rise_c) begin
          state_d = S_TRIG;
          cnt_d   = CNT_W'(1);  // the rise cycle is itself a high clock
        end
      end
      S_TRIG: begin
        armed_d = 1'b1;
        if (fall_c) begin
          cnt_d = '0;
          if (cnt_q >= CNT_W'(TRIG_MIN_CYC) && cnt_q <= CNT_W'(TRIG_MAX_CYC)) begin
            d_lat_d = distance_i;
            state_d = S_HOLDOFF;
          end else begin
            state_d = S_IDLE;
          end
        end else if (s_sig_c && cnt_q < CNT_W'(TRIG_MAX_CYC + 1)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == CNT_W'(HOLDOFF_CYC - 1)) begin
          cnt_d     = '0;
          state_d   = S_ECHO;
          sig_out_d = 1'b1;
          sig_oe_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ECHO: begin
        sig_oe_d = 1'b1;
        if (cnt_q == w_clamp_c - CNT_W'(1)) begin
          cnt_d       = '0;
          state_d     = S_RELEASE;
          echo_done_d = 1'b1;
        end else begin
          cnt_d     = cnt_q + CNT_W'(1);
          sig_out_d = 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_d   = '0;
        state_d = S_RECOVER;
      end
      S_RECOVER: begin
        if (cnt_q == CNT_W'(RECOVER_CYC - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State, counter and output registers; reset releases the pad immediately.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      d_lat_q     <= '0;
      armed_q     <= 1'b0;
      sig_out_o   <= 1'b0;
      sig_oe_o    <= 1'b0;
      busy_o      <= 1'b0;
      echo_done_o <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      d_lat_q     <= d_lat_d;
      armed_q     <= armed_d;
      sig_out_o   <= sig_out_d;
      sig_oe_o    <= sig_oe_d;
      busy_o      <= busy_d;
      echo_done_o <= echo_done_d;
    end
  end

endmodule
